// File: rtl/timing_pkg.sv
// Shared encodings for the 6502 cycle-timing sequencer.
// One-hot T-state layout and the one-hot to index conversion.
package timing_pkg;

    localparam int TW = 7;

    localparam logic [2:0] T0_IDX = 3'd0;
    localparam logic [2:0] T1_IDX = 3'd1;
    localparam logic [2:0] T2_IDX = 3'd2;
    localparam logic [2:0] T3_IDX = 3'd3;
    localparam logic [2:0] T4_IDX = 3'd4;
    localparam logic [2:0] T5_IDX = 3'd5;
    localparam logic [2:0] T6_IDX = 3'd6;

    typedef logic [TW-1:0] tstate_t;
    typedef logic [2:0]    tcnt_t;

    localparam tstate_t T0_OH = tstate_t'(1) << T0_IDX;
    localparam tstate_t T1_OH = tstate_t'(1) << T1_IDX;

    function automatic tcnt_t tcnt_of(input tstate_t t);
        tcnt_t idx;
        idx = '0;
        for (int i = 0; i < TW; i++) begin
            if (t[i]) idx = idx | tcnt_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/timing_gen_if.sv
// Bundle between the timing sequencer and the decoder/random logic.
// master is the sequencer side, slave is the random-logic side.
interface timing_gen_if;
    import timing_pkg::*;

    logic  RDY;
    logic  WR;
    logic  LAST;
    logic  SKIP0;
    logic  NMI_P;
    logic  IRQ_P;

    logic  T0;
    logic  T1;
    logic  T2;
    logic  T3;
    logic  T4;
    logic  T5;
    logic  T6;
    tcnt_t TCNT;
    logic  SYNC;
    logic  STALL;
    logic  RESP;
    logic  INTF;
    logic  TERR;

    modport master (
        input  RDY, WR, LAST, SKIP0, NMI_P, IRQ_P,
        output T0, T1, T2, T3, T4, T5, T6,
        output TCNT, SYNC, STALL, RESP, INTF, TERR
    );

    modport slave (
        output RDY, WR, LAST, SKIP0, NMI_P, IRQ_P,
        input  T0, T1, T2, T3, T4, T5, T6,
        input  TCNT, SYNC, STALL, RESP, INTF, TERR
    );

endinterface

// File: rtl/timing_gen.sv
// One-hot T-state sequencer for the 6502 core: steps T0..T6,
// applies RDY stalls, LAST/SKIP0 termination and fetch flags.
module timing_gen
    import timing_pkg::*;
(
    input  logic         PHI0,
    input  logic         _RES,
    timing_gen_if.master bus
);

    tstate_t t_q;
    tstate_t t_d;
    tcnt_t   tcnt_q;
    logic    resp_q;
    logic    resp_d;
    logic    intf_q;
    logic    intf_d;
    logic    terr_q;
    logic    terr_d;
    logic    stall;
    logic    boundary;

    assign stall = ~bus.RDY & ~bus.WR;

    // T0 always ends the instruction; SKIP0 ends it early from any other state.
    assign boundary = t_q[T0_IDX] | bus.SKIP0;

    always_comb begin
        t_d    = t_q;
        resp_d = resp_q;
        intf_d = intf_q;
        terr_d = terr_q;
        if (!stall) begin
            if (boundary) begin
                t_d    = T1_OH;
                resp_d = 1'b0;
                intf_d = bus.NMI_P | bus.IRQ_P;
            end else if (bus.LAST) begin
                t_d = T0_OH;
            end else if (t_q[T6_IDX]) begin
                t_d    = T0_OH;
                terr_d = 1'b1;
            end else begin
                t_d = {t_q[TW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge PHI0) begin
        if (!_RES) begin
            t_q    <= T1_OH;
            tcnt_q <= T1_IDX;
            resp_q <= 1'b1;
            intf_q <= 1'b0;
            terr_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            tcnt_q <= tcnt_of(t_d);
            resp_q <= resp_d;
            intf_q <= intf_d;
            terr_q <= terr_d;
        end
    end

    assign bus.T0    = t_q[T0_IDX];
    assign bus.T1    = t_q[T1_IDX];
    assign bus.T2    = t_q[T2_IDX];
    assign bus.T3    = t_q[T3_IDX];
    assign bus.T4    = t_q[T4_IDX];
    assign bus.T5    = t_q[T5_IDX];
    assign bus.T6    = t_q[T6_IDX];
    assign bus.TCNT  = tcnt_q;
    assign bus.SYNC  = t_q[T1_IDX];
    assign bus.STALL = stall;
    assign bus.RESP  = resp_q;
    assign bus.INTF  = intf_q;
    assign bus.TERR  = terr_q;

endmodule

// File: tb/tb_timing_gen.sv
// Bench for timing_gen: directed vector table, a hand-written
// write/stall sequence, and random stimulus against a cycle model.
module tb_timing_gen;
    import timing_pkg::*;

    logic PHI0 = 1'b0;
    logic _RES = 1'b0;

    timing_gen_if bus ();

    timing_gen dut (
        .PHI0 (PHI0),
        ._RES (_RES),
        .bus  (bus)
    );

    always #5 PHI0 = ~PHI0;

    typedef struct {
        logic res, rdy, wr, last, skip0, nmi, irq;
        int   tcnt;
        logic resp, intf, terr;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // reference model state: active T index and flags
    int   m_t    = 1;
    logic m_resp = 1'b1;
    logic m_intf = 1'b0;
    logic m_terr = 1'b0;

    function automatic vec_t mk(
        input logic res, rdy, wr, last, skip0, nmi, irq,
        input int tcnt, input logic resp, intf, terr);
        vec_t v;
        v.res = res; v.rdy = rdy; v.wr = wr; v.last = last;
        v.skip0 = skip0; v.nmi = nmi; v.irq = irq;
        v.tcnt = tcnt; v.resp = resp; v.intf = intf; v.terr = terr;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(input logic res, rdy, wr, last,
                        input logic skip0, nmi, irq);
        logic [6:0] tv;
        @(negedge PHI0);
        _RES = res; bus.RDY = rdy; bus.WR = wr;
        bus.LAST = last; bus.SKIP0 = skip0;
        bus.NMI_P = nmi; bus.IRQ_P = irq;
        #1;
        chk("stall", 32'(bus.STALL), 32'(!rdy && !wr));
        @(posedge PHI0);
        if (!res) begin
            m_t = 1; m_resp = 1'b1; m_intf = 1'b0; m_terr = 1'b0;
        end else if (rdy || wr) begin
            if (m_t == 0 || skip0) begin
                m_t = 1; m_resp = 1'b0; m_intf = nmi | irq;
            end else if (last) begin
                m_t = 0;
            end else if (m_t == 6) begin
                m_t = 0; m_terr = 1'b1;
            end else begin
                m_t = m_t + 1;
            end
        end
        #1;
        tv = {bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1, bus.T0};
        chk("onehot", 32'($countones(tv)), 32'd1);
        chk("tvec", 32'(tv), 32'(1 << m_t));
        chk("tcnt_vs_t", 32'(bus.TCNT), 32'(tcnt_of(tv)));
        chk("tcnt", 32'(bus.TCNT), 32'(m_t));
        chk("sync", 32'(bus.SYNC), 32'(m_t == 1));
        chk("resp", 32'(bus.RESP), 32'(m_resp));
        chk("intf", 32'(bus.INTF), 32'(m_intf));
        chk("terr", 32'(bus.TERR), 32'(m_terr));
    endtask

    vec_t vecs[$];

    initial begin
        bus.RDY = 1'b1; bus.WR = 1'b0; bus.LAST = 1'b0;
        bus.SKIP0 = 1'b0; bus.NMI_P = 1'b0; bus.IRQ_P = 1'b0;

        vecs.push_back(mk(0,1,0,0,0,0,0, 1,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 1,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 3,1,0,0));
        vecs.push_back(mk(1,1,0,1,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,0,1,1,1,1, 2,0,0,0));
        vecs.push_back(mk(1,0,0,1,1,1,1, 2,0,0,0));
        vecs.push_back(mk(1,0,0,1,1,1,1, 2,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 3,0,0,0));
        vecs.push_back(mk(1,1,0,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,0,0, 3,0,0,0));
        vecs.push_back(mk(1,1,0,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,0,0,0));
        vecs.push_back(mk(1,1,0,1,1,0,1, 1,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 3,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 4,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 5,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 6,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0,0,1,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 1,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 3,0,0,1));
        vecs.push_back(mk(1,1,0,0,0,0,0, 4,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 1,1,0,0));
        vecs.push_back(mk(1,1,0,1,0,0,0, 0,1,0,0));
        vecs.push_back(mk(1,1,0,1,1,1,0, 1,0,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 2,0,1,0));

        foreach (vecs[i]) begin
            step(vecs[i].res, vecs[i].rdy, vecs[i].wr, vecs[i].last,
                 vecs[i].skip0, vecs[i].nmi, vecs[i].irq);
            chk($sformatf("vec%0d_tcnt", i), 32'(bus.TCNT), 32'(vecs[i].tcnt));
            chk($sformatf("vec%0d_resp", i), 32'(bus.RESP), 32'(vecs[i].resp));
            chk($sformatf("vec%0d_intf", i), 32'(bus.INTF), 32'(vecs[i].intf));
            chk($sformatf("vec%0d_terr", i), 32'(bus.TERR), 32'(vecs[i].terr));
        end

        // write with RDY low still advances, T0 stall holds, write leaves T0
        step(0,1,0,0,0,0,0);
        step(1,0,1,1,0,0,0);
        chk("wr_last_t0", 32'(bus.T0), 32'd1);
        step(1,0,0,0,0,1,1);
        chk("t0_stall_hold", 32'(bus.TCNT), 32'd0);
        chk("t0_stall_resp", 32'(bus.RESP), 32'd1);
        step(1,0,1,0,0,0,1);
        chk("t0_wr_t1", 32'(bus.SYNC), 32'd1);
        chk("t0_wr_intf", 32'(bus.INTF), 32'd1);
        chk("t0_wr_resp", 32'(bus.RESP), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 18,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timing_gen.md
# timing_gen

Cycle-timing sequencer for the 6502 core. It owns the one-hot T-state register (T0..T6) that steps the random control logic and decoder through each instruction, and it generates SYNC. It applies RDY stalls, early instruction termination (LAST, SKIP0) and the reset/interrupt fetch flags. It sits between the decoder/random-logic outputs and their T-state inputs, so each instruction's cycle sequence is decided here.

## Interface
- No parameters; all encodings are fixed in `timing_pkg`.
- `PHI0`  in  1  clock; all state updates on rising edge
- `_RES`  in  1  reset, synchronous, active-low
- `RDY`  in  1  ready; 0 stalls read cycles
- `WR`  in  1  current cycle is a write (from random logic)
- `LAST`  in  1  current cycle is the last execute cycle of the instruction
- `SKIP0`  in  1  instruction ends now without a T0 cycle (branch not taken / no page cross)
- `NMI_P`  in  1  NMI pending (edge already latched upstream)
- `IRQ_P`  in  1  IRQ pending and unmasked
- `T0..T6`  out  1 each  one-hot T-state, registered
- `TCNT`  out  3  index of active T-state (0..6), registered
- `SYNC`  out  1  opcode fetch cycle; equals T1
- `STALL`  out  1  combinational, ~RDY & ~WR
- `RESP`  out  1  reset sequence in progress, registered
- `INTF`  out  1  current instruction is an interrupt sequence (forced BRK), registered
- `TERR`  out  1  sticky: T6 overflowed without termination

## Operation
- Reset (`_RES`=0 at an edge): T1=1, all other T outputs 0, TCNT=1, RESP=1, INTF=0, TERR=0. This state holds while `_RES` stays low.
- The first cycle after reset release is T1, the reset-sequence fetch.
- Next-state priority at each edge, highest first:
  1. Reset.
  2. Stall: RDY=0 & WR=0 holds all registers unchanged.
  3. State T0: go to T1 unconditionally; LAST and SKIP0 are ignored.
  4. SKIP0=1 in T1..T6: go to T1, with no T0.
  5. LAST=1 in T1..T6: go to T0.
  6. T6 with neither LAST nor SKIP0: go to T0 and set TERR=1.
  7. Otherwise: step Tn to Tn+1.
- If LAST and SKIP0 are both high, SKIP0 wins and the next state is T1.
- On writes, RDY is ignored: WR=1 always advances the state.
- Two-cycle instructions assert LAST in T1, giving the sequence T1, T0, T1.
- Flags update only on a T0→T1 transition:
  - RESP is cleared.
  - INTF is loaded with NMI_P | IRQ_P.
- A SKIP0 jump to T1 is also a start-of-instruction transition: RESP is cleared and INTF is loaded the same way.
- Flags are held during stalls.
- TERR clears only on reset.
- Invariant: exactly one T output is high in every cycle, and TCNT matches that output.

## Timing
- All outputs except STALL and SYNC are registered and change only on the rising edge of PHI0.
- SYNC is a direct copy of the T1 register. STALL is combinational from RDY and WR.
- LAST or SKIP0 sampled at the end of cycle n takes effect in cycle n+1; latency is one cycle.
- NMI_P and IRQ_P are sampled only at the edge leaving T0 or taking SKIP0. A pending interrupt raised at any other time waits for the next instruction boundary.
- A stall of k cycles extends the current T-state by exactly k cycles. No inputs are consumed during a stall.
- Reset asserted mid-instruction takes effect at the next edge regardless of RDY or WR.

## Structure
- `timing_pkg` contains:
  - state index constants `T0_IDX`..`T6_IDX` (0..6)
  - the one-hot width constant `TW`=7
  - a `tstate_t` typedef, logic [TW-1:0]
  - the function converting one-hot to the TCNT index
- `timing_gen` is a single module with no sub-modules. It holds:
  - the next-state combinational block
  - the T register
  - the flag registers
- Implementation target is 120–200 lines.

## Test plan
- Reset then release, RDY=1, LAST asserted in T3:
  - required sequence T1, T2, T3, T0, T1
  - SYNC high in both T1 cycles
  - RESP drops at the second T1
  - TCNT reads 1, 2, 3, 0, 1
- RDY=0 for 3 cycles in T2 with WR=0:
  - T2 and STALL=1 held for 3 extra cycles, then T3
- Repeat with WR=1:
  - no stall; T2 advances to T3 immediately; STALL=0
- SKIP0 and LAST both high in T2:
  - next state is T1 (not T0)
  - with IRQ_P=1 at that edge, INTF=1 for the new instruction
- No LAST or SKIP0 from T1 through T6:
  - T6 is followed by T0, then T1
  - TERR=1 and stays set until `_RES`=0
- `_RES`=0 asserted in T4 during a stall (RDY=0):
  - next edge gives T1=1, RESP=1, INTF=0, TERR=0
- Every scenario, every cycle: exactly one T output is high and TCNT is consistent with it.
